// File: rtl/el_phase_detector_if.sv
// Serial-in / recovered-bit bundle of the early-late phase detector.
// The master side drives ena/din; the slave side is the detector.
interface el_phase_detector_if #(
  parameter int PH_W = 3
) ();
  logic            ena;
  logic            din;
  logic            rx_bit;
  logic            rx_valid;
  logic            vote_early;
  logic            vote_late;
  logic            phase_skip;
  logic            phase_hold;
  logic            locked;
  logic [PH_W-1:0] phase;

  modport master (
    output ena, din,
    input  rx_bit, rx_valid, vote_early, vote_late, phase_skip, phase_hold, locked, phase
  );

  modport slave (
    input  ena, din,
    output rx_bit, rx_valid, vote_early, vote_late, phase_skip, phase_hold, locked, phase
  );
endinterface

// File: rtl/el_phase_detector.sv
// Bang-bang CDR: oversamples din, recovers one bit per OSR clks, integrates
// early/late votes and slips its own sampling phase by one clk at threshold.
module el_phase_detector #(
  parameter int OSR      = 8,
  parameter int THRESH   = 8,
  parameter int ACC_W    = 5,
  parameter int LOCK_CNT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  el_phase_detector_if.slave  pd
);
  localparam int PH_W = $clog2(OSR);
  localparam int LC_W = $clog2(LOCK_CNT + 1);

  localparam logic [PH_W-1:0]         PH_T   = '0;
  localparam logic [PH_W-1:0]         PH_D   = PH_W'(OSR / 2);
  localparam logic [PH_W-1:0]         PH_ONE = PH_W'(1);
  localparam logic [PH_W-1:0]         PH_TWO = PH_W'(2);
  localparam logic signed [ACC_W-1:0] ACC_1  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] THR_P  = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] THR_N  = -THR_P;
  localparam logic [LC_W-1:0]         LC_MAX = LC_W'(LOCK_CNT);
  localparam logic [LC_W-1:0]         LC_ONE = LC_W'(1);

  logic [1:0]              sync_q;
  logic                    din_s;

  logic [PH_W-1:0]         ph_q,       ph_d;
  logic signed [ACC_W-1:0] acc_q,      acc_d;
  logic                    t_q,        t_d;
  logic                    d_q,        d_d;
  logic                    prev_ok_q,  prev_ok_d;
  logic                    rx_bit_q,   rx_bit_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    early_q,    early_d;
  logic                    late_q,     late_d;
  logic                    skip_q,     skip_d;
  logic                    hold_q,     hold_d;
  logic [LC_W-1:0]         lock_cnt_q, lock_cnt_d;

  logic                    trans, v_late, v_early, adj_skip, adj_hold;
  logic signed [ACC_W-1:0] acc_inc, acc_dec;

  // Two-flop synchroniser keeps running while ena=0 so din_s is settled on resume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], pd.din};
  end
  assign din_s = sync_q[1];

  // At the D capture d_q still holds the previous symbol (Dp of this vote)
  assign trans    = prev_ok_q && (din_s != d_q);
  assign v_late   = trans && (t_q == din_s);
  assign v_early  = trans && (t_q == d_q);
  assign acc_inc  = acc_q + ACC_1;
  assign acc_dec  = acc_q - ACC_1;
  assign adj_skip = v_late  && (acc_inc == THR_P);
  assign adj_hold = v_early && (acc_dec == THR_N);

  always_comb begin
    ph_d       = ph_q;
    acc_d      = acc_q;
    t_d        = t_q;
    d_d        = d_q;
    prev_ok_d  = prev_ok_q;
    rx_bit_d   = rx_bit_q;
    rx_valid_d = rx_valid_q;
    early_d    = early_q;
    late_d     = late_q;
    skip_d     = skip_q;
    hold_d     = hold_q;
    lock_cnt_d = lock_cnt_q;
    if (pd.ena) begin
      rx_valid_d = 1'b0;
      early_d    = 1'b0;
      late_d     = 1'b0;
      skip_d     = 1'b0;
      hold_d     = 1'b0;
      // Adjustment pulses sit at ph==OSR/2+1, so ph 0 and OSR/2 are never skipped or repeated
      if (skip_q)       ph_d = ph_q + PH_TWO;
      else if (!hold_q) ph_d = ph_q + PH_ONE;
      if (ph_q == PH_T) t_d = din_s;
      if (ph_q == PH_D) begin
        d_d        = din_s;
        prev_ok_d  = 1'b1;
        rx_valid_d = 1'b1;
        rx_bit_d   = din_s;
        early_d    = v_early;
        late_d     = v_late;
        skip_d     = adj_skip;
        hold_d     = adj_hold;
        if (adj_skip || adj_hold) acc_d = '0;
        else if (v_late)          acc_d = acc_inc;
        else if (v_early)         acc_d = acc_dec;
        if (adj_skip || adj_hold)      lock_cnt_d = '0;
        else if (lock_cnt_q != LC_MAX) lock_cnt_d = lock_cnt_q + LC_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q       <= '0;
      acc_q      <= '0;
      t_q        <= 1'b0;
      d_q        <= 1'b0;
      prev_ok_q  <= 1'b0;
      rx_bit_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      early_q    <= 1'b0;
      late_q     <= 1'b0;
      skip_q     <= 1'b0;
      hold_q     <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      ph_q       <= ph_d;
      acc_q      <= acc_d;
      t_q        <= t_d;
      d_q        <= d_d;
      prev_ok_q  <= prev_ok_d;
      rx_bit_q   <= rx_bit_d;
      rx_valid_q <= rx_valid_d;
      early_q    <= early_d;
      late_q     <= late_d;
      skip_q     <= skip_d;
      hold_q     <= hold_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Pulses are frozen with the rest of the state; masking them keeps a pulse
  // interrupted by ena=0 from showing twice.
  assign pd.rx_bit     = rx_bit_q;
  assign pd.rx_valid   = rx_valid_q & pd.ena;
  assign pd.vote_early = early_q    & pd.ena;
  assign pd.vote_late  = late_q     & pd.ena;
  assign pd.phase_skip = skip_q     & pd.ena;
  assign pd.phase_hold = hold_q     & pd.ena;
  assign pd.locked     = (lock_cnt_q == LC_MAX);
  assign pd.phase      = ph_q;

  a_adj_excl: assert property (@(posedge clk) disable iff (!rst_n) !(skip_q && hold_q));
  a_acc_rest: assert property (@(posedge clk) disable iff (!rst_n) (acc_q < THR_P) && (acc_q > THR_N));
endmodule
